// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//
// Integer execute stage between decode and the memory stage. An op offered by
// decode is captured in the ID/EX slot, its source operands are forwarded from
// EX/MEM or writeback, the ALU is evaluated, and the result is registered in
// the EX/MEM slot for the memory stage. Both slots use valid/ready handshakes.
//
// Parameters
//   DATA_SIZE  operand/result width (32)
//   REG_AW     register address width (5)
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid / o_ready       decode handshake into the ID/EX slot
//   i_funct                 ALU operation (4-bit code, see ALU_* constants)
//   i_sel_a, i_sel_b        operand select: pc for A, imm for B when set
//   i_rs1/rs2_addr/data     source indices and regfile read data
//   i_pc, i_imm             op pc and sign-extended immediate
//   i_rd_addr, i_rd_we      destination index and write enable
//   i_wb_we/addr/data       writeback stage, second-priority forward source
//   i_flush                 kill all in-flight ops
//   o_valid / i_ready       memory-stage handshake out of the EX/MEM slot
//   o_result, o_store_data  registered ALU result and forwarded rs2 value
//   o_rd_addr, o_rd_we      registered destination fields
//   o_stall_cnt             backpressure cycle counter
//
// Build option
//   EXECUTE_STAGE_PERF_EN   when defined, o_stall_cnt counts cycles in which
//                           a result is held by backpressure (saturating).
//                           Otherwise it is tied to zero and has no flops.
// ---------------------------------------------------------------------------
module execute_stage #(
    parameter int DATA_SIZE = 32,
    parameter int REG_AW    = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [3:0]           i_funct,
    input  logic                 i_sel_a,
    input  logic                 i_sel_b,
    input  logic [REG_AW-1:0]    i_rs1_addr,
    input  logic [REG_AW-1:0]    i_rs2_addr,
    input  logic [DATA_SIZE-1:0] i_rs1_data,
    input  logic [DATA_SIZE-1:0] i_rs2_data,
    input  logic [DATA_SIZE-1:0] i_pc,
    input  logic [DATA_SIZE-1:0] i_imm,
    input  logic [REG_AW-1:0]    i_rd_addr,
    input  logic                 i_rd_we,
    input  logic                 i_wb_we,
    input  logic [REG_AW-1:0]    i_wb_addr,
    input  logic [DATA_SIZE-1:0] i_wb_data,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_SIZE-1:0] o_result,
    output logic [DATA_SIZE-1:0] o_store_data,
    output logic [REG_AW-1:0]    o_rd_addr,
    output logic                 o_rd_we,
    output logic [31:0]          o_stall_cnt
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam int SHAMT_W = $clog2(DATA_SIZE);

    typedef struct packed {
        logic                 valid;
        logic [3:0]           funct;
        logic                 sel_a;
        logic                 sel_b;
        logic [REG_AW-1:0]    rs1_addr;
        logic [REG_AW-1:0]    rs2_addr;
        logic [REG_AW-1:0]    rd_addr;
        logic                 rd_we;
        logic [DATA_SIZE-1:0] rs1_data;
        logic [DATA_SIZE-1:0] rs2_data;
        logic [DATA_SIZE-1:0] pc;
        logic [DATA_SIZE-1:0] imm;
    } ide_t;

    typedef struct packed {
        logic                 valid;
        logic [DATA_SIZE-1:0] result;
        logic [DATA_SIZE-1:0] store_data;
        logic [REG_AW-1:0]    rd_addr;
        logic                 rd_we;
    } em_t;

    ide_t ide_q, ide_d;
    em_t  em_q, em_d;

    logic                 em_adv;
    logic                 accept;
    logic [DATA_SIZE-1:0] fwd_rs1;
    logic [DATA_SIZE-1:0] fwd_rs2;
    logic [DATA_SIZE-1:0] op_a;
    logic [DATA_SIZE-1:0] op_b;
    logic [DATA_SIZE-1:0] alu_res;

    // EX/MEM may take a new op when empty or when its content leaves this
    // cycle; ID/EX may accept whenever its content is leaving too, so a full
    // pipeline still sustains one op per cycle.
    assign em_adv  = !em_q.valid || i_ready;
    assign o_ready = !ide_q.valid || em_adv;
    assign accept  = i_valid && o_ready && !i_flush;

    // x0 never forwards. EX/MEM is younger than writeback, so it wins.
    function automatic logic [DATA_SIZE-1:0] fwd(
        input logic [REG_AW-1:0]    addr,
        input logic [DATA_SIZE-1:0] latched
    );
        if (addr == '0)
            return '0;
        else if (em_q.valid && em_q.rd_we && (em_q.rd_addr == addr))
            return em_q.result;
        else if (i_wb_we && (i_wb_addr == addr))
            return i_wb_data;
        else
            return latched;
    endfunction

    // Forwarding is re-evaluated every cycle, so a stalled op picks up
    // producers that arrive while it waits.
    always_comb begin
        fwd_rs1 = fwd(ide_q.rs1_addr, ide_q.rs1_data);
        fwd_rs2 = fwd(ide_q.rs2_addr, ide_q.rs2_data);
        op_a    = ide_q.sel_a ? ide_q.pc  : fwd_rs1;
        op_b    = ide_q.sel_b ? ide_q.imm : fwd_rs2;
    end

    // Combinational ALU; unknown codes produce zero.
    always_comb begin
        alu_res = '0;
        case (ide_q.funct)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLL:  alu_res = op_a << op_b[SHAMT_W-1:0];
            ALU_SRL:  alu_res = op_a >> op_b[SHAMT_W-1:0];
            ALU_SRA:  alu_res = $signed(op_a) >>> op_b[SHAMT_W-1:0];
            ALU_SLT:  alu_res = {{(DATA_SIZE-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(DATA_SIZE-1){1'b0}}, (op_a < op_b)};
            default:  alu_res = '0;
        endcase
    end

    // Flush takes priority over both an accept and an advance.
    always_comb begin
        ide_d = ide_q;
        if (i_flush) begin
            ide_d.valid = 1'b0;
        end else if (accept) begin
            ide_d.valid    = 1'b1;
            ide_d.funct    = i_funct;
            ide_d.sel_a    = i_sel_a;
            ide_d.sel_b    = i_sel_b;
            ide_d.rs1_addr = i_rs1_addr;
            ide_d.rs2_addr = i_rs2_addr;
            ide_d.rd_addr  = i_rd_addr;
            ide_d.rd_we    = i_rd_we;
            ide_d.rs1_data = i_rs1_data;
            ide_d.rs2_data = i_rs2_data;
            ide_d.pc       = i_pc;
            ide_d.imm      = i_imm;
        end else if (em_adv) begin
            ide_d.valid = 1'b0;
        end
    end

    // Payload fields only change when a valid op moves in, so a held
    // result stays stable under backpressure.
    always_comb begin
        em_d = em_q;
        if (i_flush) begin
            em_d.valid = 1'b0;
        end else if (em_adv) begin
            em_d.valid = ide_q.valid;
            if (ide_q.valid) begin
                em_d.result     = alu_res;
                em_d.store_data = fwd_rs2;
                em_d.rd_addr    = ide_q.rd_addr;
                em_d.rd_we      = ide_q.rd_we;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ide_q <= '0;
            em_q  <= '0;
        end else begin
            ide_q <= ide_d;
            em_q  <= em_d;
        end
    end

    assign o_valid      = em_q.valid;
    assign o_result     = em_q.result;
    assign o_store_data = em_q.store_data;
    assign o_rd_addr    = em_q.rd_addr;
    assign o_rd_we      = em_q.rd_we;

`ifdef EXECUTE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (em_q.valid && !i_ready && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign o_stall_cnt = stall_cnt_q;
`else
    assign o_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
//
// Drives directed scenarios followed by random traffic into execute_stage and
// compares every cycle against a transaction-level model: a queue of waiting
// ops plus one held result, with ALU results computed from plain arithmetic.
// ---------------------------------------------------------------------------
module tb_execute_stage;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd9;

    typedef struct {
        logic [3:0]  funct;
        bit          selA;
        bit          selB;
        logic [4:0]  rs1;
        logic [31:0] d1;
        logic [4:0]  rs2;
        logic [31:0] d2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        bit          we;
    } op_t;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        iValid = 1'b0;
    logic        oReady;
    logic [3:0]  iFunct = '0;
    logic        iSelA = 1'b0;
    logic        iSelB = 1'b0;
    logic [4:0]  iRs1Addr = '0;
    logic [4:0]  iRs2Addr = '0;
    logic [31:0] iRs1Data = '0;
    logic [31:0] iRs2Data = '0;
    logic [31:0] iPc = '0;
    logic [31:0] iImm = '0;
    logic [4:0]  iRdAddr = '0;
    logic        iRdWe = 1'b0;
    logic        iWbWe = 1'b0;
    logic [4:0]  iWbAddr = '0;
    logic [31:0] iWbData = '0;
    logic        iFlush = 1'b0;
    logic        oValid;
    logic        iReady = 1'b0;
    logic [31:0] oResult;
    logic [31:0] oStoreData;
    logic [4:0]  oRdAddr;
    logic        oRdWe;
    logic [31:0] oStallCnt;

    int total = 0;
    int bad = 0;

    // Reference model state
    op_t         curOp;
    op_t         pendQ[$];
    bit          mValid = 1'b0;
    logic [31:0] mResult = '0;
    logic [31:0] mStore = '0;
    logic [4:0]  mRd = '0;
    bit          mWe = 1'b0;
    bit          mLegal = 1'b0;
    logic [31:0] mStall = '0;

    always #5 clk = ~clk;

    execute_stage #(.DATA_SIZE(32), .REG_AW(5)) dut (
        .i_clk(clk), .i_rst_n(rstN),
        .i_valid(iValid), .o_ready(oReady),
        .i_funct(iFunct), .i_sel_a(iSelA), .i_sel_b(iSelB),
        .i_rs1_addr(iRs1Addr), .i_rs2_addr(iRs2Addr),
        .i_rs1_data(iRs1Data), .i_rs2_data(iRs2Data),
        .i_pc(iPc), .i_imm(iImm),
        .i_rd_addr(iRdAddr), .i_rd_we(iRdWe),
        .i_wb_we(iWbWe), .i_wb_addr(iWbAddr), .i_wb_data(iWbData),
        .i_flush(iFlush),
        .o_valid(oValid), .i_ready(iReady),
        .o_result(oResult), .o_store_data(oStoreData),
        .o_rd_addr(oRdAddr), .o_rd_we(oRdWe),
        .o_stall_cnt(oStallCnt)
    );

    // Reference ALU from the instruction semantics.
    function automatic logic [31:0] aluRef(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        int sa;
        int sb;
        logic [31:0] ones;
        sh = int'(b & 32'd31);
        sa = a;
        sb = b;
        ones = 32'hFFFF_FFFF;
        case (f)
            4'd0: return a + b;
            4'd1: return a + (~b + 32'd1);
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
            4'd8: return (sa < sb) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwdRef(input logic [4:0] rs, input logic [31:0] latched);
        if (rs == 5'd0) return 32'd0;
        if (mValid && mWe && mRd == rs) return mResult;
        if (iWbWe && iWbAddr == rs) return iWbData;
        return latched;
    endfunction

    function automatic op_t mkOp(input logic [3:0] f, input bit sa, input bit sb,
                                 input logic [4:0] r1, input logic [31:0] d1,
                                 input logic [4:0] r2, input logic [31:0] d2,
                                 input logic [31:0] imm, input logic [4:0] rd, input bit we);
        op_t o;
        o.funct = f; o.selA = sa; o.selB = sb;
        o.rs1 = r1; o.d1 = d1; o.rs2 = r2; o.d2 = d2;
        o.pc = 32'h0000_1000; o.imm = imm; o.rd = rd; o.we = we;
        return o;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compares every DUT output against the model after a clock edge.
    task automatic checkOutput();
        checkVal("o_valid", oValid, mValid);
        if (mValid) begin
            checkVal("o_rd_addr", oRdAddr, mRd);
            checkVal("o_rd_we", oRdWe, mWe);
            checkVal("o_store_data", oStoreData, mStore);
            if (mLegal) checkVal("o_result", oResult, mResult);
        end
`ifdef EXECUTE_STAGE_PERF_EN
        checkVal("o_stall_cnt", oStallCnt, mStall);
`else
        checkVal("o_stall_cnt", oStallCnt, 32'd0);
`endif
    endtask

    // One clock cycle: drive curOp and wb globals, check o_ready, advance
    // the model at the edge, then check the registered outputs.
    task automatic applyStimulus(input bit v, input bit rdy, input bit fl);
        bit readyExp;
        bit emAdv;
        bit oldValid;
        op_t p;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
        iValid = v; iReady = rdy; iFlush = fl;
        iFunct = curOp.funct; iSelA = curOp.selA; iSelB = curOp.selB;
        iRs1Addr = curOp.rs1; iRs1Data = curOp.d1;
        iRs2Addr = curOp.rs2; iRs2Data = curOp.d2;
        iPc = curOp.pc; iImm = curOp.imm; iRdAddr = curOp.rd; iRdWe = curOp.we;
        readyExp = (pendQ.size() == 0) || !mValid || rdy;
        #1;
        checkVal("o_ready", oReady, readyExp);
        @(posedge clk);
        emAdv = !mValid || rdy;
        oldValid = mValid;
        if (fl) begin
            pendQ.delete();
            mValid = 1'b0;
        end else begin
            if (emAdv) begin
                if (pendQ.size() > 0) begin
                    p = pendQ.pop_front();
                    a = p.selA ? p.pc : fwdRef(p.rs1, p.d1);
                    st = fwdRef(p.rs2, p.d2);
                    b = p.selB ? p.imm : st;
                    mResult = aluRef(p.funct, a, b);
                    mStore = st;
                    mRd = p.rd;
                    mWe = p.we;
                    mLegal = (p.funct <= 4'd9);
                    mValid = 1'b1;
                end else begin
                    mValid = 1'b0;
                end
            end
            if (v && readyExp) pendQ.push_back(curOp);
        end
        if (oldValid && !rdy && mStall != 32'hFFFF_FFFF) mStall = mStall + 32'd1;
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    initial begin
        curOp = mkOp(OP_ADD, 0, 0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 0);
        #3;
        checkVal("rst_valid", oValid, 1'b0);
        checkVal("rst_result", oResult, 32'd0);
        checkVal("rst_store", oStoreData, 32'd0);
        checkVal("rst_rd", oRdAddr, 5'd0);
        checkVal("rst_we", oRdWe, 1'b0);
        checkVal("rst_stall", oStallCnt, 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        $display("[TB] basic ADD");
        curOp = mkOp(OP_ADD, 0, 0, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd3, 1);
        applyStimulus(1, 1, 0);
        applyStimulus(0, 1, 0);
        checkVal("t1_result", oResult, 32'd12);
        checkVal("t1_rd", oRdAddr, 5'd3);
        checkVal("t1_we", oRdWe, 1'b1);

        $display("[TB] EX/MEM forward");
        curOp = mkOp(OP_ADD, 0, 1, 5'd4, 32'd4, 5'd0, 32'd0, 32'd6, 5'd1, 1);
        applyStimulus(1, 1, 0);
        curOp = mkOp(OP_SUB, 0, 1, 5'd1, 32'd0, 5'd0, 32'd0, 32'd4, 5'd2, 1);
        applyStimulus(1, 1, 0);
        applyStimulus(0, 1, 0);
        checkVal("t2_result", oResult, 32'd6);

        $display("[TB] x0 never forwards");
        iWbWe = 1'b1; iWbAddr = 5'd0; iWbData = 32'd99;
        curOp = mkOp(OP_ADD, 0, 1, 5'd0, 32'd55, 5'd0, 32'd0, 32'd3, 5'd7, 1);
        applyStimulus(1, 1, 0);
        applyStimulus(0, 1, 0);
        checkVal("t3_result", oResult, 32'd3);
        iWbWe = 1'b0;

        $display("[TB] backpressure");
        curOp = mkOp(OP_ADD, 0, 0, 5'd8, 32'd1, 5'd9, 32'd2, 32'd0, 5'd10, 1);
        applyStimulus(1, 1, 0);
        curOp = mkOp(OP_ADD, 0, 1, 5'd8, 32'd20, 5'd0, 32'd0, 32'd5, 5'd11, 1);
        applyStimulus(1, 1, 0);
        curOp = mkOp(OP_SUB, 0, 0, 5'd12, 32'd50, 5'd13, 32'd8, 32'd0, 5'd14, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0);
        checkVal("t4_oready", oReady, 1'b0);
        checkVal("t4_held", oResult, 32'd3);
`ifdef EXECUTE_STAGE_PERF_EN
        checkVal("t4_stall", oStallCnt, 32'd4);
`else
        checkVal("t4_stall", oStallCnt, 32'd0);
`endif
        applyStimulus(1, 1, 0);
        checkVal("t4_second", oResult, 32'd25);
        applyStimulus(0, 1, 0);
        checkVal("t4_third", oResult, 32'd42);
        applyStimulus(0, 1, 0);

        $display("[TB] flush");
        curOp = mkOp(OP_ADD, 0, 1, 5'd15, 32'd1, 5'd0, 32'd0, 32'd1, 5'd16, 1);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 1);
        checkVal("t5_flushed", oValid, 1'b0);
        applyStimulus(0, 1, 0);
        checkVal("t5_none", oValid, 1'b0);

        $display("[TB] SRA / SLTU");
        curOp = mkOp(OP_SRA, 0, 1, 5'd1, 32'hFFFF_FFF8, 5'd0, 32'd0, 32'd1, 5'd5, 1);
        applyStimulus(1, 1, 0);
        curOp = mkOp(OP_SLTU, 0, 0, 5'd1, 32'd1, 5'd2, 32'hFFFF_FFFF, 32'd0, 5'd6, 1);
        applyStimulus(1, 1, 0);
        checkVal("t6_sra", oResult, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 0);
        checkVal("t6_sltu", oResult, 32'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic [3:0] f;
            f = 4'($urandom_range(0, 11));
            curOp = mkOp(f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         5'($urandom_range(0, 3)), $urandom(),
                         5'($urandom_range(0, 3)), $urandom(),
                         $urandom(), 5'($urandom_range(0, 3)),
                         (f <= 4'd9) ? 1'($urandom_range(0, 1)) : 1'b0);
            curOp.pc = $urandom();
            iWbWe = 1'($urandom_range(0, 1));
            iWbAddr = 5'($urandom_range(0, 3));
            iWbData = $urandom();
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 19) == 0));
        end
        iWbWe = 1'b0;

        $display("[TB] async reset during stall");
        curOp = mkOp(OP_ADD, 0, 1, 5'd1, 32'd3, 5'd0, 32'd0, 32'd9, 5'd2, 1);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        #2;
        rstN = 1'b0;
        #1;
        checkVal("t7_valid", oValid, 1'b0);
        checkVal("t7_result", oResult, 32'd0);
        checkVal("t7_store", oStoreData, 32'd0);
        checkVal("t7_rd", oRdAddr, 5'd0);
        checkVal("t7_we", oRdWe, 1'b0);
        checkVal("t7_stall", oStallCnt, 32'd0);
        pendQ.delete();
        mValid = 1'b0;
        mStall = '0;
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
